fifo_ctrl: RTL

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_ptr_counter.sv | 40 ++++
 rtl/fifo_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO controller.
// Holds the controller FSM state encoding and the default entry count.
package fifo_pkg;

    localparam int FIFO_DEFAULT_DEPTH = 32;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        NORMAL = 2'd1,
        FULL   = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_ptr_counter.sv
// Purpose: enable-driven wrap counter 0..DEPTH-1, used as a FIFO RAM pointer.
// Latency: count updates on the clock edge after en_i; clr_i is synchronous and dominates.
// Backpressure: none; the caller gates en_i with its own accept condition.
module fifo_ptr_counter
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [AW-1:0] cnt_o
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    // Explicit wrap so non-power-of-two depths never index past the RAM.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Purpose: FIFO controller (pointers, occupancy, flags) for an external RAM; optional almost flags via FIFO_ALMOST_FLAGS_EN.
// Latency: flags/occupancy registered one cycle after a request; oWE is combinational; read data one cycle after accept.
// Backpressure: writes refused while full, reads refused while empty; a refused request pulses oERROR.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
`endif
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iWRITE,
    input  logic          iREAD,
    output logic          oWE,
    output logic [AW-1:0] oWR_ADDR,
    output logic [AW-1:0] oRD_ADDR,
    output logic [AW:0]   oUSEDW,
    output logic          oFULL,
    output logic          oEMPTY,
    output logic          oERROR
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    output logic          oALMOST_FULL,
    output logic          oALMOST_EMPTY
`endif
);

    localparam logic [AW:0] USEDW_ONE  = (AW+1)'(1);
    localparam logic [AW:0] USEDW_LAST = (AW+1)'(DEPTH - 1);

    state_t      state_q, state_d;
    logic [AW:0] usedw_q, usedw_d;
    logic        full_q, empty_q, error_q;
    logic        error_d;
    logic        wr_acc, rd_acc;

    assign wr_acc = iWRITE && (state_q != FULL);
    assign rd_acc = iREAD  && (state_q != EMPTY);

    always_comb begin
        usedw_d = usedw_q;
        state_d = state_q;
        error_d = (iWRITE && (state_q == FULL)) || (iREAD && (state_q == EMPTY));

        case ({wr_acc, rd_acc})
            2'b10:   usedw_d = usedw_q + USEDW_ONE;
            2'b01:   usedw_d = usedw_q - USEDW_ONE;
            default: usedw_d = usedw_q;
        endcase

        case (state_q)
            EMPTY: begin
                if (wr_acc) state_d = NORMAL;
            end
            NORMAL: begin
                if (wr_acc && !rd_acc && (usedw_q == USEDW_LAST)) begin
                    state_d = FULL;
                end else if (rd_acc && !wr_acc && (usedw_q == USEDW_ONE)) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (rd_acc) state_d = NORMAL;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= EMPTY;
            usedw_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            usedw_q <= usedw_d;
            full_q  <= (state_d == FULL);
            empty_q <= (state_d == EMPTY);
            error_q <= error_d;
        end
    end

    fifo_ptr_counter #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_wr_ptr (
        .clk_i (iCLK),
        .clr_i (iRST),
        .en_i  (wr_acc),
        .cnt_o (oWR_ADDR)
    );

    fifo_ptr_counter #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rd_ptr (
        .clk_i (iCLK),
        .clr_i (iRST),
        .en_i  (rd_acc),
        .cnt_o (oRD_ADDR)
    );

    // Strobe follows the registered full flag so it matches the address shown this cycle.
    assign oWE    = iWRITE && !full_q;
    assign oUSEDW = usedw_q;
    assign oFULL  = full_q;
    assign oEMPTY = empty_q;
    assign oERROR = error_q;

`ifdef FIFO_ALMOST_FLAGS_EN
    localparam logic [AW:0] AF_THR = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_THR = (AW+1)'(AE_LEVEL);

    logic afull_q, aempty_q;

    // Computed from next occupancy so the flags move with oUSEDW, not a cycle behind.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            afull_q  <= ({(AW+1){1'b0}} >= AF_THR);
            aempty_q <= 1'b1;
        end else begin
            afull_q  <= (usedw_d >= AF_THR);
            aempty_q <= (usedw_d <= AE_THR);
        end
    end

    assign oALMOST_FULL  = afull_q;
    assign oALMOST_EMPTY = aempty_q;
`endif

endmodule
